mux_scanner: RTL
================

# mux_scanner

Sequential controller that sits around the 4:1 `multiplexer`. It drives the multiplexer's `sel` input, reads its `signal` output back, and collects one sample per input channel into a 4-bit snapshot. Each channel's `sel` value is held for a programmable settle time before sampling. The snapshot is delivered downstream over a valid/ready handshake, in one-shot or continuous scanning mode.

## Interface
Parameters:
- `DWELL`, default 2: cycles `sel` is held per channel before its sample is taken; legal range 1..255.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: begin a scan; sampled only in IDLE.
- `continuous` input 1: when 1, a new scan starts immediately after each delivered snapshot; sampled at handshake.
- `signal` input 1: the multiplexer output for the channel currently selected.
- `sel` output 2: channel select to the multiplexer.
- `snap` output 4: last completed snapshot; bit k holds the `signal` value sampled while `sel`=k.
- `snap_valid` output 1: `snap` holds an undelivered snapshot.
- `snap_ready` input 1: downstream accepts `snap` when both `snap_valid` and `snap_ready` are high.
- `changed` output 1: the current `snap` differs from the previously delivered snapshot.
- `busy` output 1: high in any state other than IDLE.

## Operation
- State machine: IDLE, SETTLE, OUTPUT.
- Internal registers: channel index `ch` (2 bits), dwell counter `cnt` (8 bits), shadow snapshot `shd` (4 bits), and `prev` (last delivered snapshot).
- Channel `sel` is driven from `ch`. In IDLE and OUTPUT, `sel` is 00.

IDLE:
- On an edge with `start`=1: go to SETTLE with `ch`=0, `cnt`=0, `shd`=0000.

SETTLE:
- While `cnt` < `DWELL`-1: `cnt` increments each cycle.
- On the edge where `cnt`==`DWELL`-1:
  - Write `shd[ch]` = `signal`.
  - If `ch` < 3: increment `ch` and clear `cnt`.
  - If `ch`==3: go to OUTPUT. On that same edge, load `snap` with the completed shadow (including the bit just sampled), set `snap_valid`=1, and set `changed` = (new `snap` != `prev`).

OUTPUT:
- `snap`, `snap_valid` and `changed` are held stable until the handshake.
- On handshake: `prev` ← `snap` and `snap_valid` ← 0.
  - If `continuous`=1: go to SETTLE with `ch`=0, `cnt`=0, `shd`=0000.
  - Otherwise: go to IDLE.
- `snap` retains its value after the handshake until the next scan completes.

Start and mode rules:
- `start` is ignored outside IDLE.
- `continuous` is ignored outside the handshake cycle.

Reset:
- Values: state IDLE, `sel`=00, `snap`=0000, `snap_valid`=0, `changed`=0, `busy`=0, `prev`=0000, `ch`=0, `cnt`=0.
- Reset overrides every other event in the same cycle, including a handshake.
- Reset during a scan discards `shd` and produces no snapshot.

## Timing
- Label the edge that samples `start`=1 as E0. Channel k is sampled at edge E((k+1)·`DWELL`).
- `snap_valid` rises at edge E(4·`DWELL`). This gives a scan latency of 4·`DWELL` cycles, e.g. 8 for `DWELL`=2.
- `sel` is stable for exactly `DWELL` cycles per channel, so the combinational multiplexer output is settled at every sample.
- With `continuous`=1 and `snap_ready` held at 1, OUTPUT lasts one cycle. The scan period is then 4·`DWELL`+1 cycles.
- `changed` is registered and only updates on the edge that raises `snap_valid`. The first snapshot after reset is compared against 0000.
- `busy` rises on the edge after E0... more precisely, `busy` is 1 from E0 onward and falls on the handshake edge that returns the block to IDLE.

## Test plan
- Reset: assert `rst` for 2 cycles with `start`=1 → `sel`=00, `snap`=0000, `snap_valid`=0, `busy`=0, and no scan starts while `rst` is high.
- Single scan, `DWELL`=2, multiplexer inputs a1..a4 = 1,0,1,1, `snap_ready`=1 → `sel` sequence 00,00,01,01,10,10,11,11; `snap`=4'b1101 with `snap_valid` high at E8 for one cycle; `changed`=1; then IDLE.
- Backpressure: same stimulus with `snap_ready` low for 5 cycles after `snap_valid` rises → `snap_valid`, `snap`=1101 and `sel`=00 all held; the handshake on the 6th cycle returns the block to IDLE. Pulsing `start` during OUTPUT has no effect.
- Continuous mode with `DWELL`=1: inputs 0,1,1,0, then 0,1,1,0 again, then 1,1,1,1 → snapshots 0110 (`changed`=1), 0110 (`changed`=0), 1111 (`changed`=1), delivered every 5 cycles.
- Reset mid-scan: assert `rst` at E3 of a `DWELL`=2 scan → no `snap_valid`, `snap` keeps 0000, and a following `start` produces a full 8-cycle scan from channel 0.
- `DWELL`=1 boundary with inputs changing every cycle → each bit of `snap` equals `signal` at the edge ending that channel's single `sel` cycle.

Source files
------------

// File: rtl/mux_scanner.sv
// mux_scanner: steps a 4:1 multiplexer through its channels, samples each after a
// settle time, and hands the 4-bit snapshot downstream over valid/ready.
`default_nettype none

module mux_scanner #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic       signal,
  output logic [1:0] sel,
  output logic [3:0] snap,
  output logic       snap_valid,
  input  logic       snap_ready,
  output logic       changed,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] ch;
  logic [7:0] cnt;
  logic [3:0] shd;
  logic [3:0] prev;
  logic [3:0] shd_done;
  logic       dwell_done;
  logic       handshake;

  assign dwell_done = (cnt == LAST);
  assign handshake  = (state == OUTPUT) && snap_ready;
  assign sel        = (state == SETTLE) ? ch : 2'b00;
  assign busy       = (state != IDLE);

  // Shadow with the bit for the current channel replaced by the live sample,
  // so the final channel lands in snap on the same edge it is sampled.
  always_comb begin
    shd_done     = shd;
    shd_done[ch] = signal;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (dwell_done && ch == 2'd3) state_nxt = OUTPUT;
      OUTPUT:  if (snap_ready) state_nxt = continuous ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch         <= 2'd0;
      cnt        <= 8'd0;
      shd        <= 4'd0;
      snap       <= 4'd0;
      snap_valid <= 1'b0;
      changed    <= 1'b0;
      prev       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ch  <= 2'd0;
            cnt <= 8'd0;
            shd <= 4'd0;
          end
        end
        SETTLE: begin
          if (!dwell_done) begin
            cnt <= cnt + 8'd1;
          end else begin
            shd <= shd_done;
            if (ch != 2'd3) begin
              ch  <= ch + 2'd1;
              cnt <= 8'd0;
            end else begin
              snap       <= shd_done;
              snap_valid <= 1'b1;
              changed    <= (shd_done != prev);
            end
          end
        end
        OUTPUT: begin
          if (handshake) begin
            prev       <= snap;
            snap_valid <= 1'b0;
            if (continuous) begin
              ch  <= 2'd0;
              cnt <= 8'd0;
              shd <= 4'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
